acc_step_feeder: RTL and testbench

Segment sequencer that feeds the acceleration step generator over its load/done/abort protocol. It buffers up to DEPTH (dt, steps) segment descriptors pushed by the host over a valid/ready port. It issues the first segment on `start`, then issues each following segment the cycle after the generator reports `done`. It stops the generator cleanly on an end marker, on `stop`, or after an underrun abort.

---
 rtl/acc_step_feeder.sv | 206 ++++++++++++++++++++
 tb/tb_acc_step_feeder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_step_feeder.sv
// acc_step_feeder
// Buffers (dt, steps) segment descriptors from a host and feeds them to the
// acceleration step generator over its load/done/abort protocol.
//
// Handshake: a host push happens on a rising edge where seg_valid && seg_ready
// and reset is low; seg_ready is high whenever the queue is not full and does
// not depend on seg_valid. The generator side has no back-pressure: load is a
// one-cycle pulse, and done/abort/step_stb are sampled every cycle.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   seg_dt, seg_steps           descriptor being pushed (dt==0 marks end of program)
//   seg_valid / seg_ready       host push handshake
//   start, stop                 begin execution / flush and halt
//   step_stb, done, abort       generator status inputs
//   load                        one-cycle pulse presenting a new descriptor
//   dt_val, steps_val           descriptor (held after load)
//   set_dt_limit, set_steps_limit, reset_dt, reset_steps   load qualifiers
//   busy, underrun, level       status: not idle, sticky abort flag, occupancy
//   seg_count, step_count       completed segments / steps since start
//   state_dbg                   current FSM state (IDLE=0 RUN=1 STARVE=2 HALT=3)
module acc_step_feeder #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                seg_dt,
  input  logic [31:0]                seg_steps,
  input  logic                       seg_valid,
  output logic                       seg_ready,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       step_stb,
  input  logic                       done,
  input  logic                       abort,
  output logic                       load,
  output logic [31:0]                dt_val,
  output logic [31:0]                steps_val,
  output logic                       set_dt_limit,
  output logic                       set_steps_limit,
  output logic                       reset_dt,
  output logic                       reset_steps,
  output logic                       busy,
  output logic                       underrun,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                seg_count,
  output logic [31:0]                step_count,
  output logic [1:0]                 state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_ONE  = 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STARVE = 2'd2, HALT = 2'd3} state_t;

  state_t state_q, state_d;

  // Queue storage and pointers
  logic [31:0]   mem_dt    [DEPTH];
  logic [31:0]   mem_steps [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   head_dt, head_steps;
  logic          have_seg;
  logic          push;

  // Set when stop/abort arrives in the same cycle as a load; the stop load is
  // then issued from HALT one cycle later so load never pulses back to back.
  logic stop_pend, stop_pend_d;

  // Decoded actions for this cycle
  logic pop, flush, issue_seg, first_seg, issue_stop, set_underrun, clear_run;
  logic seg_inc, step_inc;

  assign head_dt    = mem_dt[rd_ptr];
  assign head_steps = mem_steps[rd_ptr];
  assign have_seg   = (level != '0);
  assign seg_ready  = (level != LVL_FULL);
  assign push       = seg_valid && seg_ready && !flush;
  assign busy       = (state_q != IDLE);
  assign state_dbg  = state_q;

  assign seg_inc  = (state_q == RUN || state_q == STARVE) && done && !abort;
  assign step_inc = (state_q != IDLE) && step_stb && !abort;

  always_comb begin
    state_d      = state_q;
    stop_pend_d  = stop_pend;
    pop          = 1'b0;
    flush        = 1'b0;
    issue_seg    = 1'b0;
    first_seg    = 1'b0;
    issue_stop   = 1'b0;
    set_underrun = 1'b0;
    clear_run    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && have_seg) begin
          pop       = 1'b1;
          issue_seg = 1'b1;
          first_seg = 1'b1;
          clear_run = 1'b1;
          // An end marker as the first segment leaves the generator to
          // self-terminate, so there is nothing to supervise.
          state_d   = (head_dt == '0) ? IDLE : RUN;
        end
      end
      RUN, STARVE: begin
        if (abort) set_underrun = 1'b1;
        if (stop || abort) begin
          flush   = 1'b1;
          state_d = HALT;
          if (load) stop_pend_d = 1'b1;
          else      issue_stop  = 1'b1;
        end else if (!load && have_seg &&
                     ((state_q == RUN && done) || state_q == STARVE)) begin
          pop       = 1'b1;
          issue_seg = 1'b1;
          state_d   = (head_dt == '0) ? IDLE : RUN;
        end else if (state_q == RUN && done) begin
          state_d = STARVE;
        end
      end
      HALT: begin
        if (abort) set_underrun = 1'b1;
        if (stop_pend) begin
          issue_stop  = 1'b1;
          stop_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Queue payload: no reset needed, occupancy tracks validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dt[wr_ptr]    <= seg_dt;
      mem_steps[wr_ptr] <= seg_steps;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      stop_pend       <= 1'b0;
      load            <= 1'b0;
      set_dt_limit    <= 1'b0;
      set_steps_limit <= 1'b0;
      reset_dt        <= 1'b0;
      reset_steps     <= 1'b0;
      dt_val          <= '0;
      steps_val       <= '0;
      underrun        <= 1'b0;
      seg_count       <= '0;
      step_count      <= '0;
      level           <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
    end else begin
      state_q         <= state_d;
      stop_pend       <= stop_pend_d;
      load            <= issue_seg | issue_stop;
      set_dt_limit    <= issue_seg | issue_stop;
      set_steps_limit <= issue_seg | issue_stop;
      reset_steps     <= issue_seg | issue_stop;
      // Later segments keep the running step interval (reset_dt=0).
      reset_dt        <= first_seg | issue_stop;
      if (issue_seg) begin
        dt_val    <= head_dt;
        steps_val <= head_steps;
      end else if (issue_stop) begin
        dt_val    <= '0;
        steps_val <= '0;
      end

      if (clear_run) begin
        seg_count  <= '0;
        step_count <= '0;
        underrun   <= 1'b0;
      end else begin
        if (seg_inc)      seg_count  <= seg_count + 16'd1;
        if (step_inc)     step_count <= step_count + 32'd1;
        if (set_underrun) underrun   <= 1'b1;
      end

      if (flush) begin
        level  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + LVL_ONE;
          2'b01:   level <= level - LVL_ONE;
          default: level <= level;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acc_step_feeder.sv
// Directed bench for acc_step_feeder. Stimulus pushes the expected load
// descriptor {dt, steps, reset_dt, reset_steps, set_dt_limit, set_steps_limit}
// into exp_q; a monitor pops and compares on every load pulse.
module tb_acc_step_feeder;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] seg_dt = '0, seg_steps = '0;
  logic        seg_valid = 1'b0, start = 1'b0, stop = 1'b0;
  logic        step_stb = 1'b0, done = 1'b0, abort = 1'b0;
  logic        seg_ready, load, set_dt_limit, set_steps_limit, reset_dt, reset_steps;
  logic        busy, underrun;
  logic [31:0] dt_val, steps_val, step_count;
  logic [2:0]  level;
  logic [15:0] seg_count;
  logic [1:0]  state_dbg;

  logic [67:0] exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic        prev_load = 1'b0;

  acc_step_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .seg_dt(seg_dt), .seg_steps(seg_steps),
    .seg_valid(seg_valid), .seg_ready(seg_ready), .start(start), .stop(stop),
    .step_stb(step_stb), .done(done), .abort(abort), .load(load),
    .dt_val(dt_val), .steps_val(steps_val), .set_dt_limit(set_dt_limit),
    .set_steps_limit(set_steps_limit), .reset_dt(reset_dt), .reset_steps(reset_steps),
    .busy(busy), .underrun(underrun), .level(level), .seg_count(seg_count),
    .step_count(step_count), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: compares every load pulse against the queue head.
  always @(negedge clk) begin
    if (!reset && load) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_load: got dt=%0d steps=%0d expected no load", dt_val, steps_val);
      end else begin
        logic [67:0] e;
        logic [67:0] a;
        e = exp_q.pop_front();
        a = {dt_val, steps_val, reset_dt, reset_steps, set_dt_limit, set_steps_limit};
        if (a !== e) begin
          n_fail++;
          $display("FAIL load_desc: got %0h expected %0h", a, e);
        end
      end
      n_cmp++;
      if (prev_load) begin
        n_fail++;
        $display("FAIL load_back_to_back: got 1 expected 0");
      end
    end
    prev_load = load;
  end

  // Driver tasks (inputs change on the falling edge)
  task automatic tick(); @(negedge clk); endtask

  task automatic push_seg(input logic [31:0] dt, input logic [31:0] st);
    seg_dt = dt; seg_steps = st; seg_valid = 1'b1;
    tick();
    seg_valid = 1'b0;
  endtask

  task automatic expect_load(input logic [31:0] dt, input logic [31:0] st, input logic rdt);
    exp_q.push_back({dt, st, rdt, 1'b1, 1'b1, 1'b1});
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic gen_steps(input int n);
    for (int i = 0; i < n; i++) begin
      step_stb = 1'b1; tick();
    end
    step_stb = 1'b0;
  endtask

  task automatic gen_done();
    done = 1'b1; tick(); done = 1'b0;
  endtask

  task automatic do_stop();
    expect_load(32'd0, 32'd0, 1'b1);
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    tick(); tick();
    check("rst_load", {67'd0, load}, 68'd0);
    check("rst_busy", {67'd0, busy}, 68'd0);
    check("rst_level", {65'd0, level}, 68'd0);
    check("rst_seg_ready", {67'd0, seg_ready}, 68'd1);
    check("rst_counts", {20'd0, seg_count, step_count}, 68'd0);
    check("rst_dt_val", {36'd0, dt_val}, 68'd0);
    reset = 1'b0;
    tick();

    // Three-segment program ending with a marker
    push_seg(32'd10, 32'd3);
    push_seg(32'd20, 32'd2);
    push_seg(32'd0, 32'd0);
    check("t1_level3", {65'd0, level}, 68'd3);
    expect_load(32'd10, 32'd3, 1'b1);
    do_start();
    check("t1_busy_after_start", {67'd0, busy}, 68'd1);
    check("t1_level_after_pop", {65'd0, level}, 68'd2);
    gen_steps(3);
    expect_load(32'd20, 32'd2, 1'b0);
    gen_done();
    check("t1_chain_load", {67'd0, load}, 68'd1);
    check("t1_seg_count1", {52'd0, seg_count}, 68'd1);
    gen_steps(2);
    expect_load(32'd0, 32'd0, 1'b0);
    gen_done();
    check("t1_end_load", {67'd0, load}, 68'd1);
    check("t1_seg_count2", {52'd0, seg_count}, 68'd2);
    check("t1_step_count", {36'd0, step_count}, 68'd5);
    check("t1_busy0", {67'd0, busy}, 68'd0);
    check("t1_underrun0", {67'd0, underrun}, 68'd0);
    tick();

    // Full queue, ignored extra push, simultaneous push and pop
    push_seg(32'd1, 32'd1);
    push_seg(32'd2, 32'd2);
    push_seg(32'd3, 32'd3);
    push_seg(32'd4, 32'd4);
    check("t2_full_ready", {67'd0, seg_ready}, 68'd0);
    check("t2_full_level", {65'd0, level}, 68'd4);
    push_seg(32'd9, 32'd9);
    check("t2_extra_ignored", {65'd0, level}, 68'd4);
    expect_load(32'd1, 32'd1, 1'b1);
    do_start();
    check("t2_level3", {65'd0, level}, 68'd3);
    gen_steps(1);
    expect_load(32'd2, 32'd2, 1'b0);
    seg_dt = 32'd5; seg_steps = 32'd5; seg_valid = 1'b1; done = 1'b1;
    tick();
    seg_valid = 1'b0; done = 1'b0;
    check("t2_push_pop_level", {65'd0, level}, 68'd3);
    gen_steps(1);
    expect_load(32'd3, 32'd3, 1'b0);
    gen_done();
    gen_steps(1);
    expect_load(32'd4, 32'd4, 1'b0);
    gen_done();
    gen_steps(1);
    expect_load(32'd5, 32'd5, 1'b0);
    gen_done();
    gen_steps(1);
    gen_done();
    check("t2_starve_busy", {67'd0, busy}, 68'd1);
    check("t2_starve_state", {66'd0, state_dbg}, 68'd2);
    do_stop();
    check("t2_stop_level", {65'd0, level}, 68'd0);
    tick();
    check("t2_stop_idle", {67'd0, busy}, 68'd0);

    // Underrun abort
    push_seg(32'd5, 32'd2);
    expect_load(32'd5, 32'd2, 1'b1);
    do_start();
    gen_steps(2);
    gen_done();
    check("t3_no_load_starve", {67'd0, load}, 68'd0);
    expect_load(32'd0, 32'd0, 1'b1);
    abort = 1'b1; step_stb = 1'b1;
    tick();
    abort = 1'b0; step_stb = 1'b0;
    check("t3_stop_load", {67'd0, load}, 68'd1);
    check("t3_underrun", {67'd0, underrun}, 68'd1);
    check("t3_flush", {65'd0, level}, 68'd0);
    check("t3_step_count", {36'd0, step_count}, 68'd2);
    tick();
    check("t3_busy0", {67'd0, busy}, 68'd0);
    check("t3_underrun_sticky", {67'd0, underrun}, 68'd1);

    // Late-load recovery from STARVE
    push_seg(32'd5, 32'd2);
    expect_load(32'd5, 32'd2, 1'b1);
    do_start();
    check("t4_start_clears_underrun", {67'd0, underrun}, 68'd0);
    gen_steps(2);
    gen_done();
    tick(); tick();
    expect_load(32'd5, 32'd1, 1'b0);
    push_seg(32'd5, 32'd1);
    check("t4_no_load_push1", {67'd0, load}, 68'd0);
    tick();
    check("t4_load_push2", {67'd0, load}, 68'd1);
    check("t4_underrun0", {67'd0, underrun}, 68'd0);
    check("t4_busy", {67'd0, busy}, 68'd1);
    gen_steps(1);
    gen_done();
    do_stop();
    tick();

    // Mid-run stop with two queued, then start on empty queue
    push_seg(32'd7, 32'd4);
    push_seg(32'd8, 32'd4);
    push_seg(32'd9, 32'd4);
    expect_load(32'd7, 32'd4, 1'b1);
    do_start();
    gen_steps(1);
    do_stop();
    check("t5_stop_level", {65'd0, level}, 68'd0);
    check("t5_step_count", {36'd0, step_count}, 68'd1);
    tick();
    check("t5_busy0", {67'd0, busy}, 68'd0);
    do_start();
    check("t5_empty_start_ignored", {67'd0, busy}, 68'd0);

    // Reset mid-segment with a chaining load pending
    push_seg(32'd3, 32'd1);
    push_seg(32'd4, 32'd1);
    expect_load(32'd3, 32'd1, 1'b1);
    do_start();
    gen_steps(1);
    done = 1'b1; reset = 1'b1;
    tick();
    done = 1'b0;
    check("t6_load0", {67'd0, load}, 68'd0);
    check("t6_busy0", {67'd0, busy}, 68'd0);
    check("t6_level0", {65'd0, level}, 68'd0);
    check("t6_vals0", {4'd0, dt_val, steps_val}, 68'd0);
    check("t6_counts0", {20'd0, seg_count, step_count}, 68'd0);
    reset = 1'b0;
    tick();
    check("t6_seg_ready", {67'd0, seg_ready}, 68'd1);
    tick(); tick();

    check("all_loads_seen", 68'(exp_q.size()), 68'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
